// File: rtl/lab7_key_pkg.sv
// Shared definitions for the push-button key interrupt controller.
// Register map addresses and the per-key debounce state encoding.
package lab7_key_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    typedef enum logic {
        STABLE,
        COUNTING
    } deb_state_e;

endpackage

// File: rtl/lab7_key_debounce.sv
// One key: two-flop synchronizer followed by a counting debouncer.
// A level change is accepted after it holds for DEBOUNCE_CYCLES cycles.
module lab7_key_debounce
    import lab7_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic din,
    output logic dout
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             sync;
    deb_state_e       state_q;
    deb_state_e       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             deb_q;
    logic             deb_d;

    assign sync = sync_q[1];
    assign dout = deb_q;

    // Bring the raw pin into the clk domain; idle high = released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], din};
        end
    end

    // Debounce state, counter and accepted level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            deb_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            deb_q   <= deb_d;
        end
    end

    // Restart on any bounce; accept on the last counted cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        deb_d   = deb_q;
        unique case (state_q)
            STABLE: begin
                if (sync != deb_q) begin
                    state_d = COUNTING;
                    cnt_d   = CNT_ONE;
                end else begin
                    cnt_d = '0;
                end
            end
            COUNTING: begin
                if (sync == deb_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                    deb_d   = sync;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/lab7_soc_key_irq_ctrl.sv
// Avalon-MM key controller: debounced key levels, sticky press flags,
// per-key interrupt mask and a registered level interrupt.
module lab7_soc_key_irq_ctrl
    import lab7_key_pkg::*;
#(
    parameter int WIDTH           = 2,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] deb;
    logic [WIDTH-1:0] deb_prev_q;
    logic [WIDTH-1:0] press;
    logic [WIDTH-1:0] irqmask_q;
    logic [WIDTH-1:0] edgecap_q;
    logic [WIDTH-1:0] clr_bits;
    logic             wr_en;
    logic             wr_mask;
    logic             wr_ec;
    logic [31:0]      rd_d;
    logic             unused_wd;

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        lab7_key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .reset_n(reset_n),
            .din    (in_port[i]),
            .dout   (deb[i])
        );
    end

    assign wr_en    = chipselect & ~write_n;
    assign wr_mask  = wr_en & (address == ADDR_IRQMASK);
    assign wr_ec    = wr_en & (address == ADDR_EDGECAP);
    assign clr_bits = {WIDTH{wr_ec}} & writedata[WIDTH-1:0];
    assign press    = deb_prev_q & ~deb;

    // Upper data bits have no register behind them.
    assign unused_wd = ^writedata;

    // Previous debounced level for falling-edge (press) detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            deb_prev_q <= '1;
        end else begin
            deb_prev_q <= deb;
        end
    end

    // Mask register and sticky press flags; a press beats a clear.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q <= '0;
            edgecap_q <= '0;
        end else begin
            if (wr_mask) begin
                irqmask_q <= writedata[WIDTH-1:0];
            end
            edgecap_q <= press | (edgecap_q & ~clr_bits);
        end
    end

    // Read mux; unmapped and reserved words read as zero.
    always_comb begin
        rd_d = '0;
        unique case (address)
            ADDR_DATA:    rd_d[WIDTH-1:0] = ~deb;
            ADDR_IRQMASK: rd_d[WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: rd_d[WIDTH-1:0] = edgecap_q;
            default:      rd_d = '0;
        endcase
    end

    // Registered read data and interrupt level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
            irq      <= 1'b0;
        end else begin
            readdata <= rd_d;
            irq      <= |(edgecap_q & irqmask_q);
        end
    end

endmodule

// File: tb/tb_lab7_soc_key_irq_ctrl.sv
// Directed bench for the key interrupt controller, WIDTH=2, 4-cycle debounce.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_lab7_soc_key_irq_ctrl;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [1:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int total;
    int bad;

    lab7_soc_key_irq_ctrl #(
        .WIDTH          (2),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .in_port   (in_port),
        .readdata  (readdata),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
    endtask

    task automatic test_reset;
        tick(2);
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL reset_rd got=%h exp=%h", readdata, 32'h0);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        reset_n = 1'b1;
        address = 2'd0;
        tick(1);
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_data got=%h exp=%h", readdata, 32'h0);
        end
        address = 2'd2;
        tick(1);
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_mask got=%h exp=%h", readdata, 32'h0);
        end
        address = 2'd3;
        tick(1);
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL rst_ec got=%h exp=%h", readdata, 32'h0);
        end
    endtask

    task automatic test_press;
        bus_write(2'd2, 32'h1);
        address = 2'd0;
        in_port = 2'b10;
        tick(6);
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL press_early got=%h exp=%h", readdata, 32'h0);
        end
        tick(1);
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL press_data got=%h exp=%h", readdata, 32'h1);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL press_irq_early got=%b exp=0", irq);
        end
        tick(1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL press_irq got=%b exp=1", irq);
        end
        address = 2'd3;
        tick(1);
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL press_ec got=%h exp=%h", readdata, 32'h1);
        end
    endtask

    task automatic test_glitch;
        bus_write(2'd3, 32'h1);
        tick(2);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL clr0_irq got=%b exp=0", irq);
        end
        address = 2'd0;
        in_port = 2'b00;
        tick(3);
        in_port = 2'b10;
        tick(10);
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL glitch_data got=%h exp=%h", readdata, 32'h1);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL glitch_irq got=%b exp=0", irq);
        end
        address = 2'd3;
        tick(1);
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL glitch_ec got=%h exp=%h", readdata, 32'h0);
        end
        in_port = 2'b00;
        tick(4);
        in_port = 2'b10;
        tick(12);
        total++;
        if (readdata !== 32'h2) begin
            bad++;
            $display("FAIL pulse4_ec got=%h exp=%h", readdata, 32'h2);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL pulse4_irq got=%b exp=0", irq);
        end
        address = 2'd0;
        tick(1);
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL pulse4_data got=%h exp=%h", readdata, 32'h1);
        end
    endtask

    task automatic test_w1c;
        in_port = 2'b11;
        tick(12);
        in_port = 2'b10;
        tick(12);
        address = 2'd3;
        tick(1);
        total++;
        if (readdata !== 32'h3) begin
            bad++;
            $display("FAIL w1c_pre got=%h exp=%h", readdata, 32'h3);
        end
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL w1c_pre_irq got=%b exp=1", irq);
        end
        bus_write(2'd3, 32'h1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL w1c_irq_hold got=%b exp=1", irq);
        end
        tick(1);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL w1c_irq got=%b exp=0", irq);
        end
        total++;
        if (readdata !== 32'h2) begin
            bad++;
            $display("FAIL w1c_ec got=%h exp=%h", readdata, 32'h2);
        end
        bus_write(2'd2, 32'hFFFF_FFFD);
        address = 2'd2;
        tick(1);
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL mask_hi got=%h exp=%h", readdata, 32'h1);
        end
        bus_write(2'd2, 32'h3);
        tick(1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL mask3_irq got=%b exp=1", irq);
        end
        bus_write(2'd2, 32'h1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL unmask_hold got=%b exp=1", irq);
        end
        tick(1);
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL unmask_irq got=%b exp=0", irq);
        end
    endtask

    task automatic test_back_to_back;
        in_port = 2'b11;
        tick(12);
        in_port = 2'b10;
        tick(12);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL b2b_pre_irq got=%b exp=1", irq);
        end
        in_port = 2'b11;
        tick(12);
        in_port = 2'b10;
        tick(6);
        address    = 2'd3;
        writedata  = 32'h1;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick(1);
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL b2b_irq0 got=%b exp=1", irq);
        end
        tick(1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL b2b_irq1 got=%b exp=1", irq);
        end
        total++;
        if (readdata !== 32'h3) begin
            bad++;
            $display("FAIL b2b_ec got=%h exp=%h", readdata, 32'h3);
        end
        tick(1);
        total++;
        if (irq !== 1'b1) begin
            bad++;
            $display("FAIL b2b_irq2 got=%b exp=1", irq);
        end
    endtask

    task automatic test_reset_midcount;
        in_port = 2'b11;
        address = 2'd2;
        tick(12);
        in_port = 2'b10;
        tick(4);
        reset_n = 1'b0;
        #1;
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL mid_rst_rd got=%h exp=%h", readdata, 32'h0);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL mid_rst_irq got=%b exp=0", irq);
        end
        tick(2);
        reset_n = 1'b1;
        address = 2'd3;
        tick(7);
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL mid_ec_early got=%h exp=%h", readdata, 32'h0);
        end
        tick(1);
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL mid_ec got=%h exp=%h", readdata, 32'h1);
        end
        total++;
        if (irq !== 1'b0) begin
            bad++;
            $display("FAIL mid_irq got=%b exp=0", irq);
        end
        bus_write(2'd1, 32'hFFFF_FFFF);
        tick(1);
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL rsvd_rd got=%h exp=%h", readdata, 32'h0);
        end
        address = 2'd2;
        tick(1);
        total++;
        if (readdata !== 32'h0) begin
            bad++;
            $display("FAIL rsvd_mask got=%h exp=%h", readdata, 32'h0);
        end
        address = 2'd3;
        tick(1);
        total++;
        if (readdata !== 32'h1) begin
            bad++;
            $display("FAIL rsvd_ec got=%h exp=%h", readdata, 32'h1);
        end
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        reset_n    = 1'b0;
        address    = 2'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = '0;
        in_port    = 2'b11;
        test_reset();
        test_press();
        test_glitch();
        test_w1c();
        test_back_to_back();
        test_reset_midcount();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
